// File: rtl/stack_engine.sv
// Two-register-cached hardware stack: TOS/NOS live in flops, deeper entries spill to a 1-cycle RAM.
// Optional high-water tracking is built only when STACK_HWM_EN is defined.
module stack_engine #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             CtrlRst,
    input  logic             OpValid,
    output logic             OpReady,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             ErrClr,
    output logic [WIDTH-1:0] TOS,
    output logic [WIDTH-1:0] NOS,
    output logic [PTR_W:0]   Depth,
    output logic             Empty,
    output logic             Full,
    output logic             Overflow,
    output logic             Underflow,
    output logic [PTR_W:0]   HighWater
);
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_DUP     = 3'b011;
    localparam logic [2:0] OP_SWAP    = 3'b100;
    localparam logic [2:0] OP_OVER    = 3'b101;
    localparam logic [2:0] OP_REPLACE = 3'b110;
    localparam logic [2:0] OP_CLEAR   = 3'b111;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO      = (PTR_W+1)'(2);
    localparam logic [PTR_W:0] THREE    = (PTR_W+1)'(3);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d, rd_q, push_val;
    logic [PTR_W:0]   depth_q, depth_d;
    logic             ovf_q, unf_q;
    logic             accept, is_empty, is_full, ge2, ge3;
    logic             need_room, need1, need2, is_push;
    logic             ovf_hit, unf_hit, ok, fill_go, mem_we;
    logic [PTR_W-1:0] wr_addr, rd_addr;
    logic [WIDTH-1:0] mem [0:DEPTH-3];

    assign accept   = OpValid && (state_q == S_IDLE);
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == CNT_FULL);
    assign ge2      = (depth_q >= TWO);
    assign ge3      = (depth_q >= THREE);
    // Entry below NOS sits at Depth-3; a push spills NOS into Depth-2.
    assign wr_addr  = PTR_W'(depth_q - TWO);
    assign rd_addr  = PTR_W'(depth_q - THREE);

    always_comb begin
        need_room = 1'b0;
        need1     = 1'b0;
        need2     = 1'b0;
        is_push   = 1'b0;
        push_val  = DataIn;
        case (Op)
            OP_PUSH:            begin need_room = 1'b1; is_push = 1'b1; end
            OP_DUP:             begin need_room = 1'b1; need1 = 1'b1; is_push = 1'b1; push_val = tos_q; end
            OP_OVER:            begin need_room = 1'b1; need2 = 1'b1; is_push = 1'b1; push_val = nos_q; end
            OP_POP, OP_REPLACE: need1 = 1'b1;
            OP_SWAP:            need2 = 1'b1;
            default:            ;
        endcase
        ovf_hit = accept && need_room && is_full;
        unf_hit = accept && ((need1 && is_empty) || (need2 && !ge2));
        ok      = accept && !ovf_hit && !unf_hit;
    end

    always_comb begin
        tos_d   = tos_q;
        nos_d   = (state_q == S_FILL) ? rd_q : nos_q;
        depth_d = depth_q;
        fill_go = 1'b0;
        mem_we  = 1'b0;
        if (ok) begin
            if (is_push) begin
                nos_d   = tos_q;
                tos_d   = push_val;
                depth_d = depth_q + ONE;
                mem_we  = ge2;
            end else begin
                case (Op)
                    OP_POP: begin
                        tos_d   = nos_q;
                        depth_d = depth_q - ONE;
                        if (ge3) fill_go = 1'b1;
                        else     nos_d   = '0;
                    end
                    OP_SWAP: begin
                        tos_d = nos_q;
                        nos_d = tos_q;
                    end
                    OP_REPLACE: tos_d = DataIn;
                    OP_CLEAR: begin
                        tos_d   = '0;
                        nos_d   = '0;
                        depth_d = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CtrlRst) begin
            state_q <= S_IDLE;
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= fill_go ? S_FILL : S_IDLE;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            // A new error in the same cycle as ErrClr keeps the flag set.
            ovf_q   <= ovf_hit | (ovf_q & ~ErrClr);
            unf_q   <= unf_hit | (unf_q & ~ErrClr);
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we)  mem[wr_addr] <= nos_q;
        if (fill_go) rd_q         <= mem[rd_addr];
    end

`ifdef STACK_HWM_EN
    logic [PTR_W:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (ErrClr)               hwm_d = depth_d;
        else if (depth_d > hwm_q) hwm_d = depth_d;
    end

    always_ff @(posedge CLK) begin
        if (CtrlRst) hwm_q <= '0;
        else         hwm_q <= hwm_d;
    end

    assign HighWater = hwm_q;
`else
    assign HighWater = '0;
`endif

    assign OpReady   = (state_q == S_IDLE);
    assign TOS       = tos_q;
    assign NOS       = nos_q;
    assign Depth     = depth_q;
    assign Empty     = is_empty;
    assign Full      = is_full;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine: a queue-based reference stack predicts each op's outcome,
// expectations are queued at drive time and popped when the DUT outputs settle.
module tb_stack_engine;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int PW = $clog2(D);

    logic          CLK = 1'b0;
    logic          CtrlRst, OpValid, ErrClr;
    logic          OpReady, Empty, Full, Overflow, Underflow;
    logic [2:0]    Op;
    logic [W-1:0]  DataIn, TOS, NOS;
    logic [PW:0]   Depth, HighWater;

    stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .CtrlRst(CtrlRst), .OpValid(OpValid), .OpReady(OpReady), .Op(Op),
        .DataIn(DataIn), .ErrClr(ErrClr), .TOS(TOS), .NOS(NOS), .Depth(Depth),
        .Empty(Empty), .Full(Full), .Overflow(Overflow), .Underflow(Underflow),
        .HighWater(HighWater)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int tos; int nos; int depth; bit ovf; bit unf; int hwm; bit fill;
    } exp_t;

    exp_t sb[$];
    int   m[$];
    bit   m_ovf, m_unf;
    int   m_hwm;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t snap(input bit fill);
        exp_t e;
        e.tos   = (m.size() > 0) ? m[0] : 0;
        e.nos   = (m.size() > 1) ? m[1] : 0;
        e.depth = m.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.hwm   = m_hwm;
        e.fill  = fill;
        return e;
    endfunction

    task automatic model_reset();
        m.delete();
        m_ovf = 0;
        m_unf = 0;
        m_hwm = 0;
        sb.push_back(snap(1'b0));
    endtask

    task automatic model_op(input logic [2:0] op, input logic [W-1:0] data, input bit clr);
        bit so = 0, su = 0, fill = 0;
        int t;
        case (op)
            3'd1: if (m.size() == D) so = 1; else m.push_front(int'(data));
            3'd2: if (m.size() == 0) su = 1;
                  else begin fill = (m.size() >= 3); void'(m.pop_front()); end
            3'd3: if (m.size() == 0) su = 1; else if (m.size() == D) so = 1; else m.push_front(m[0]);
            3'd4: if (m.size() < 2) su = 1; else begin t = m[0]; m[0] = m[1]; m[1] = t; end
            3'd5: if (m.size() < 2) su = 1; else if (m.size() == D) so = 1; else m.push_front(m[1]);
            3'd6: if (m.size() == 0) su = 1; else m[0] = int'(data);
            3'd7: m.delete();
            default: ;
        endcase
        m_ovf = so || (m_ovf && !clr);
        m_unf = su || (m_unf && !clr);
`ifdef STACK_HWM_EN
        if (clr) m_hwm = m.size();
        else if (m.size() > m_hwm) m_hwm = m.size();
`endif
        sb.push_back(snap(fill));
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("TOS",       32'(TOS),       32'(e.tos));
        chk("Depth",     32'(Depth),     32'(e.depth));
        chk("Empty",     32'(Empty),     32'(e.depth == 0));
        chk("Full",      32'(Full),      32'(e.depth == D));
        chk("Overflow",  32'(Overflow),  32'(e.ovf));
        chk("Underflow", 32'(Underflow), 32'(e.unf));
        chk("HighWater", 32'(HighWater), 32'(e.hwm));
        chk("OpReady",   32'(OpReady),   32'(!e.fill));
        if (!e.fill) begin
            chk("NOS", 32'(NOS), 32'(e.nos));
        end else begin
            // Offer a PUSH during FILL; it must be ignored.
            OpValid = 1'b1;
            Op      = 3'd1;
            DataIn  = 16'hDEAD;
            @(posedge CLK); #1;
            OpValid = 1'b0;
            Op      = 3'd0;
            chk("fill_NOS",     32'(NOS),     32'(e.nos));
            chk("fill_TOS",     32'(TOS),     32'(e.tos));
            chk("fill_Depth",   32'(Depth),   32'(e.depth));
            chk("fill_OpReady", 32'(OpReady), 32'd1);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] data, input bit clr);
        OpValid = 1'b1;
        Op      = op;
        DataIn  = data;
        ErrClr  = clr;
        model_op(op, data, clr);
        @(posedge CLK); #1;
        OpValid = 1'b0;
        Op      = 3'd0;
        ErrClr  = 1'b0;
        check_out();
    endtask

    initial begin
        CtrlRst = 1'b1;
        OpValid = 1'b0;
        ErrClr  = 1'b0;
        Op      = 3'd0;
        DataIn  = '0;
        repeat (2) @(posedge CLK);
        #1;
        CtrlRst = 1'b0;
        model_reset();
        check_out();

        // Basic push, then POP through the FILL path
        do_op(3'd1, 16'h1111, 0);
        do_op(3'd1, 16'h2222, 0);
        do_op(3'd1, 16'h3333, 0);
        do_op(3'd2, 16'h0, 0);

        // Empty-stack underflow, SWAP precondition, ErrClr
        do_op(3'd7, 16'h0, 0);
        do_op(3'd2, 16'h0, 0);
        do_op(3'd0, 16'h0, 1);
        do_op(3'd1, 16'h0005, 0);
        do_op(3'd4, 16'h0, 0);
        do_op(3'd1, 16'h0006, 0);
        do_op(3'd4, 16'h0, 0);
        do_op(3'd0, 16'h0, 1);

        // DUP / OVER / REPLACE at depth 3, then CLEAR keeps flags
        do_op(3'd7, 16'h0, 0);
        do_op(3'd1, 16'h00A1, 0);
        do_op(3'd1, 16'h00B2, 0);
        do_op(3'd1, 16'h00C3, 0);
        do_op(3'd3, 16'h0, 0);
        do_op(3'd5, 16'h0, 0);
        do_op(3'd6, 16'h0007, 0);
        do_op(3'd2, 16'h0, 0);
        do_op(3'd2, 16'h0, 0);
        do_op(3'd7, 16'h0, 0);
        do_op(3'd2, 16'h0, 0);
        do_op(3'd7, 16'h0, 0);

        // Overflow at DEPTH, ErrClr racing a new error, then drain through RAM
        do_op(3'd0, 16'h0, 1);
        for (int i = 0; i < D; i++) do_op(3'd1, 16'(16'h0100 + i), 0);
        do_op(3'd1, 16'hAAAA, 0);
        do_op(3'd1, 16'hBBBB, 1);
        do_op(3'd0, 16'h0, 1);
        do_op(3'd3, 16'h0, 0);
        do_op(3'd5, 16'h0, 0);
        for (int i = 0; i < D + 1; i++) do_op(3'd2, 16'h0, 0);

        // Random mix against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            if (op == 3'd2 && $urandom_range(0, 1) == 0) op = 3'd1;
            do_op(op, 16'($urandom), ($urandom_range(0, 9) == 0));
        end

        // Reset while a FILL is pending
        do_op(3'd7, 16'h0, 1);
        do_op(3'd1, 16'h0F01, 0);
        do_op(3'd1, 16'h0F02, 0);
        do_op(3'd1, 16'h0F03, 0);
        OpValid = 1'b1;
        Op      = 3'd2;
        @(posedge CLK); #1;
        OpValid = 1'b0;
        Op      = 3'd0;
        chk("rst_fill_OpReady", 32'(OpReady), 32'd0);
        CtrlRst = 1'b1;
        @(posedge CLK); #1;
        CtrlRst = 1'b0;
        model_reset();
        check_out();
        do_op(3'd1, 16'h0042, 0);
        do_op(3'd1, 16'h0043, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
